// File: rtl/clk_period_meter_if.sv
// Measurement bus of clk_period_meter: the slow input to be measured and the
// period / high-time results with their status flags.
interface clk_period_meter_if #(
   parameter int CNT_W = 32
);
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             timeout;
   logic             busy;

   modport master (
      output sig_in,
      input  period, high_time, meas_valid, timeout, busy
   );

   modport slave (
      input  sig_in,
      output period, high_time, meas_valid, timeout, busy
   );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous signal in clk cycles.
// Define PERIOD_METER_DUTY_EN to build the high-time counter; otherwise high_time reads 0.
module clk_period_meter #(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst,
   clk_period_meter_if.slave bus
);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       period_q;
   logic                   meas_valid_q;
   logic                   timeout_q;
   logic                   busy_q;
   logic                   s;
   logic                   rise;

`ifdef PERIOD_METER_DUTY_EN
   logic [CNT_W-1:0]       hcnt;
   logic [CNT_W-1:0]       high_q;
`endif

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;

   // NOTE: only non-blocking assignments here, so every register samples the
   // pre-edge value of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sync_q       <= '0;
         s_d          <= 1'b0;
         cnt          <= '0;
         period_q     <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
         hcnt         <= '0;
         high_q       <= '0;
`endif
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
         s_d          <= s;
         meas_valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (rise) begin
                  cnt    <= ONE;
                  state  <= MEASURE;
                  busy_q <= 1'b1;
`ifdef PERIOD_METER_DUTY_EN
                  hcnt   <= ONE;
`endif
               end
            end
            MEASURE: begin
               // A rise on the timeout cycle still counts as a measurement.
               if (rise) begin
                  period_q     <= cnt;
                  meas_valid_q <= 1'b1;
                  timeout_q    <= 1'b0;
                  cnt          <= ONE;
`ifdef PERIOD_METER_DUTY_EN
                  high_q       <= hcnt;
                  hcnt         <= ONE;
`endif
               end else if (cnt == TIMEOUT_VAL) begin
                  timeout_q <= 1'b1;
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + ONE;
`ifdef PERIOD_METER_DUTY_EN
                  hcnt <= hcnt + CNT_W'(s);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.period     = period_q;
   assign bus.meas_valid = meas_valid_q;
   assign bus.timeout    = timeout_q;
   assign bus.busy       = busy_q;
`ifdef PERIOD_METER_DUTY_EN
   assign bus.high_time  = high_q;
`else
   assign bus.high_time  = '0;
`endif
endmodule
